// File: rtl/alu_result_display_if.sv
// -----------------------------------------------------------------------------
// alu_result_display_if
//   Groups the ALU-result handshake and the display-side outputs of
//   alu_result_display into one bundle.
//
//   Signals:
//     res        4  ALU result nibble, res[0] = LSB
//     cout       1  ALU carry-out, weight 16
//     res_valid  1  res/cout valid this cycle
//     res_ready  1  block accepts a value this cycle
//     done       1  one-cycle pulse: new BCD value loaded into display shadow
//     bcd_tens   4  displayed tens digit (0..3)
//     bcd_units  4  displayed units digit (0..9)
//     seg        7  {g,f,e,d,c,b,a}
//     an         2  digit enable, one-hot: 01 = units, 10 = tens, 00 = blank
//
//   master: the ALU side / test driver (drives res, cout, res_valid)
//   slave : alu_result_display
// -----------------------------------------------------------------------------
interface alu_result_display_if;
    logic [3:0] res;
    logic       cout;
    logic       res_valid;
    logic       res_ready;
    logic       done;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_units;
    logic [6:0] seg;
    logic [1:0] an;

    modport master (
        output res, cout, res_valid,
        input  res_ready, done, bcd_tens, bcd_units, seg, an
    );

    modport slave (
        input  res, cout, res_valid,
        output res_ready, done, bcd_tens, bcd_units, seg, an
    );
endinterface

// File: rtl/alu_result_display.sv
// -----------------------------------------------------------------------------
// alu_result_display
//   Captures a 5-bit ALU result {cout, res} (0..31), converts it to two BCD
//   digits with a sequential double-dabble engine (one bit per clock), and
//   time-multiplexes both digits onto a two-digit 7-segment display.
//
//   Ports:
//     clk   single clock, all state on the rising edge
//     rst   synchronous, active-high reset
//     bus   alu_result_display_if.slave (handshake in, BCD/segment/anode out)
//
//   Parameters:
//     REFRESH_DIV     clocks per digit slot (>= 2)
//     SEG_ACTIVE_LOW  1 = inverted segment drive (common-anode); anodes unaffected
//
//   Build option:
//     BLANK_LEADING_ZERO_EN  when defined, a zero tens digit blanks the tens
//                            slot (seg off, an = 00); slot timing is unchanged.
// -----------------------------------------------------------------------------
module alu_result_display #(
    parameter int REFRESH_DIV    = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    alu_result_display_if.slave bus
);

    localparam int              CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last_step;
    logic [2:0]       step_cnt;
    logic [4:0]       bin_p0;
    logic [7:0]       bcd_p0;
    logic [7:0]       bcd_adj;
    logic [7:0]       bcd_step;
    logic [3:0]       tens_p1;
    logic [3:0]       units_p1;
    logic             shown;
    logic             done;
    logic             digit_sel;
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       an_d;
    logic [6:0]       seg_raw;

    // Double-dabble correction: a BCD nibble >= 5 would overflow past 9
    // after the next doubling, so pre-add 3.
    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] seg_polarity(input logic [6:0] raw);
        return SEG_ACTIVE_LOW ? ~raw : raw;
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; res_ready already folds in rst so nothing is accepted
    // in a reset cycle.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_step = 1'b0;
        case (state)
            IDLE: begin
                if (bus.res_valid && bus.res_ready) begin
                    accept    = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (step_cnt == 3'd4) begin
                    last_step = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: one double-dabble iteration, next value bit taken MSB first
    always_comb begin
        bcd_adj  = {dabble_adj(bcd_p0[7:4]), dabble_adj(bcd_p0[3:0])};
        bcd_step = (bcd_adj << 1) | {7'd0, bin_p0[4]};
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            bin_p0 <= {bus.cout, bus.res};
            bcd_p0 <= 8'd0;
        end else if (state == CONV) begin
            bin_p0 <= bin_p0 << 1;
            bcd_p0 <= bcd_step;
        end
    end

    // Stage p1: display shadow, only updated on the final iteration so the
    // display never shows a partial conversion
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt <= 3'd0;
            done     <= 1'b0;
            tens_p1  <= 4'd0;
            units_p1 <= 4'd0;
            shown    <= 1'b0;
        end else begin
            done <= last_step;
            if (accept) begin
                step_cnt <= 3'd0;
            end else if (state == CONV) begin
                step_cnt <= step_cnt + 3'd1;
            end
            if (last_step) begin
                tens_p1  <= bcd_step[7:4];
                units_p1 <= bcd_step[3:0];
                shown    <= 1'b1;
            end
        end
    end

    // Scan timing: free-running slot counter, digit select toggles at wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_sel   <= 1'b0;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
            digit_sel   <= ~digit_sel;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Segment and anode are both decoded from the same registered state, so
    // they switch together on the edge that moves digit_sel.
    always_comb begin
        an_d    = 2'b00;
        seg_raw = 7'h00;
        if (shown) begin
            if (!digit_sel) begin
                an_d    = 2'b01;
                seg_raw = seg_encode(units_p1);
            end else begin
`ifdef BLANK_LEADING_ZERO_EN
                if (tens_p1 != 4'd0) begin
                    an_d    = 2'b10;
                    seg_raw = seg_encode(tens_p1);
                end
`else
                an_d    = 2'b10;
                seg_raw = seg_encode(tens_p1);
`endif
            end
        end
    end

    assign bus.res_ready = (state == IDLE) && !rst;
    assign bus.done      = done;
    assign bus.bcd_tens  = tens_p1;
    assign bus.bcd_units = units_p1;
    assign bus.an        = an_d;
    assign bus.seg       = seg_polarity(seg_raw);

endmodule

// File: tb/tb_alu_result_display.sv
// -----------------------------------------------------------------------------
// tb_alu_result_display
//   Self-checking bench for alu_result_display. A cycle-level reference model
//   works from the value rules (tens = v/10, units = v%10, 5-cycle conversion,
//   slot = (cycles since reset / REFRESH_DIV) mod 2) and every output is
//   compared once per cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_result_display;

    localparam int R = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    alu_result_display_if bus();

    alu_result_display #(
        .REFRESH_DIV   (R),
        .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    int busy   = 0;   // cycles left in the current conversion, 0 = idle
    int pend   = 0;   // value being converted
    int sh_t   = 0;
    int sh_u   = 0;
    bit shown  = 1'b0;
    bit done_m = 1'b0;
    int t      = 0;   // non-reset edges since the last reset edge
    int done_seen = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            busy   = 0;
            shown  = 1'b0;
            sh_t   = 0;
            sh_u   = 0;
            done_m = 1'b0;
            t      = 0;
        end else begin
            done_m = 1'b0;
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    sh_t   = pend / 10;
                    sh_u   = pend % 10;
                    shown  = 1'b1;
                    done_m = 1'b1;
                end
            end else if (bus.res_valid) begin
                pend = 16 * int'(bus.cout) + int'(bus.res);
                busy = 5;
            end
            t++;
        end
    endtask

    task automatic compare();
        logic [1:0] exp_an;
        logic [6:0] exp_seg;
        exp_an  = 2'b00;
        exp_seg = 7'h00;
        if (shown) begin
            if (((t / R) % 2) == 0) begin
                exp_an  = 2'b01;
                exp_seg = seg_tab[sh_u];
            end else begin
`ifdef BLANK_LEADING_ZERO_EN
                if (sh_t != 0) begin
                    exp_an  = 2'b10;
                    exp_seg = seg_tab[sh_t];
                end
`else
                exp_an  = 2'b10;
                exp_seg = seg_tab[sh_t];
`endif
            end
        end
        if (bus.done === 1'b1) done_seen++;
        check("ready", 32'(bus.res_ready), 32'((busy == 0) && !rst));
        check("done",  32'(bus.done),      32'(done_m));
        check("tens",  32'(bus.bcd_tens),  32'(sh_t));
        check("units", 32'(bus.bcd_units), 32'(sh_u));
        check("an",    32'(bus.an),        32'(exp_an));
        check("seg",   32'(bus.seg),       32'(exp_seg));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        bus.res_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input logic [3:0] r, input logic c);
        bus.res       = r;
        bus.cout      = c;
        bus.res_valid = 1'b1;
        cycle();
        bus.res_valid = 1'b0;
    endtask

    initial begin
        bus.res       = 4'd0;
        bus.cout      = 1'b0;
        bus.res_valid = 1'b0;

        // Reset held 3 cycles, then release
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b0;
        idle(6);
        check("no_done_after_reset", 32'(done_seen), 32'd0);

        // Directed values: 19, 31, 9
        send(4'h3, 1'b1);
        idle(12);
        send(4'hF, 1'b1);
        idle(12);
        send(4'h9, 1'b0);
        idle(12);

        // Valid held high with changing data across conversions
        for (int i = 0; i < 20; i++) begin
            bus.res       = 4'($urandom_range(0, 15));
            bus.cout      = 1'($urandom_range(0, 1));
            bus.res_valid = 1'b1;
            cycle();
        end
        idle(8);

        // Reset during the third conversion step aborts it
        send(4'h7, 1'b1);
        idle(2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle(10);

        // Value 0 across several scan slots
        send(4'h0, 1'b0);
        idle(20);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            bus.res       = 4'($urandom_range(0, 15));
            bus.cout      = 1'($urandom_range(0, 1));
            bus.res_valid = ($urandom_range(0, 2) == 0);
            rst           = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
